// File: rtl/fib_client.sv
// Initiator for the start/done compute-core handshake: takes a job index upstream, starts the
// core, waits for done (with timeout) and returns the result downstream with saturating stats.
module fib_client #(
    parameter int unsigned DW      = 16,
    parameter int unsigned TIMEOUT = 1024,
    parameter int unsigned TW      = $clog2(TIMEOUT) + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic [DW-1:0] req_n,
    output logic [DW-1:0] core_din,
    output logic          core_start,
    input  logic [DW-1:0] core_dout,
    input  logic          core_done,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [DW-1:0] rsp_n,
    output logic [DW-1:0] rsp_value,
    output logic          rsp_timeout,
    output logic [15:0]   jobs_done,
    output logic [7:0]    timeouts
);

    typedef enum logic [1:0] {
        StIdle,
        StStart,
        StWait,
        StResp
    } state_e;

    localparam logic [TW-1:0] CntLast = TW'(TIMEOUT - 1);

    state_e        state_q, state_d;
    logic [TW-1:0] cnt_q, cnt_d;
    logic [DW-1:0] core_din_q, core_din_d;
    logic          core_start_q, core_start_d;
    logic          rsp_valid_q, rsp_valid_d;
    logic [DW-1:0] rsp_n_q, rsp_n_d;
    logic [DW-1:0] rsp_value_q, rsp_value_d;
    logic          rsp_timeout_q, rsp_timeout_d;
    logic [15:0]   jobs_done_q, jobs_done_d;
    logic [7:0]    timeouts_q, timeouts_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= StIdle;
            cnt_q         <= '0;
            core_din_q    <= '0;
            core_start_q  <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_n_q       <= '0;
            rsp_value_q   <= '0;
            rsp_timeout_q <= 1'b0;
            jobs_done_q   <= '0;
            timeouts_q    <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            core_din_q    <= core_din_d;
            core_start_q  <= core_start_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_n_q       <= rsp_n_d;
            rsp_value_q   <= rsp_value_d;
            rsp_timeout_q <= rsp_timeout_d;
            jobs_done_q   <= jobs_done_d;
            timeouts_q    <= timeouts_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        core_din_d    = core_din_q;
        rsp_n_d       = rsp_n_q;
        rsp_value_d   = rsp_value_q;
        rsp_timeout_d = rsp_timeout_q;
        jobs_done_d   = jobs_done_q;
        timeouts_d    = timeouts_q;

        unique case (state_q)
            StIdle: begin
                // req_ready is 1 here, so valid alone means acceptance
                if (req_valid) begin
                    core_din_d = req_n;
                    rsp_n_d    = req_n;
                    state_d    = StStart;
                end
            end
            StStart: begin
                cnt_d   = '0;
                state_d = StWait;
            end
            StWait: begin
                cnt_d = cnt_q + 1'b1;
                // done takes priority over the timeout limit in the same cycle
                if (core_done) begin
                    rsp_value_d   = core_dout;
                    rsp_timeout_d = 1'b0;
                    state_d       = StResp;
                end else if (cnt_q == CntLast) begin
                    rsp_value_d   = '0;
                    rsp_timeout_d = 1'b1;
                    state_d       = StResp;
                end
            end
            StResp: begin
                if (rsp_ready) begin
                    state_d = StIdle;
                    if (rsp_timeout_q) begin
                        if (timeouts_q != 8'hFF) timeouts_d = timeouts_q + 8'd1;
                    end else begin
                        if (jobs_done_q != 16'hFFFF) jobs_done_d = jobs_done_q + 16'd1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        // Registered strobes are decoded from the next state so they align with it
        core_start_d = (state_d == StStart);
        rsp_valid_d  = (state_d == StResp);
    end

    assign req_ready   = (state_q == StIdle);
    assign core_din    = core_din_q;
    assign core_start  = core_start_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_n       = rsp_n_q;
    assign rsp_value   = rsp_value_q;
    assign rsp_timeout = rsp_timeout_q;
    assign jobs_done   = jobs_done_q;
    assign timeouts    = timeouts_q;

endmodule

// File: tb/tb_fib_client.sv
// Self-checking bench for fib_client: behavioural Fibonacci core, directed handshake scenarios
// and a randomized job phase compared against an arithmetic reference.
module tb_fib_client;

    localparam int unsigned DW      = 16;
    localparam int unsigned TIMEOUT = 16;

    logic          clk;
    logic          reset;
    logic          req_valid;
    logic          req_ready;
    logic [DW-1:0] req_n;
    logic [DW-1:0] core_din;
    logic          core_start;
    logic [DW-1:0] core_dout;
    logic          core_done;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_n;
    logic [DW-1:0] rsp_value;
    logic          rsp_timeout;
    logic [15:0]   jobs_done;
    logic [7:0]    timeouts;

    fib_client #(
        .DW      (DW),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_n       (req_n),
        .core_din    (core_din),
        .core_start  (core_start),
        .core_dout   (core_dout),
        .core_done   (core_done),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_n       (rsp_n),
        .rsp_value   (rsp_value),
        .rsp_timeout (rsp_timeout),
        .jobs_done   (jobs_done),
        .timeouts    (timeouts)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;
    int exp_jobs = 0;
    int exp_to   = 0;

    function automatic logic [15:0] fib(input int n);
        logic [15:0] a, b, t;
        a = 16'd0;
        b = 16'd1;
        for (int i = 0; i < n; i++) begin
            t = a + b;
            a = b;
            b = t;
        end
        return a;
    endfunction

    // Behavioural core: done is a level, cleared on the edge that samples start
    logic          core_en;
    logic          model_done;
    logic [15:0]   model_dout;
    logic [DW-1:0] model_n;
    int            model_cnt;
    logic          force_done;
    logic [15:0]   force_dout;

    assign core_done = model_done | force_done;
    assign core_dout = force_done ? force_dout : model_dout;

    initial begin
        model_done = 1'b0;
        model_dout = '0;
        model_n    = '0;
        model_cnt  = 0;
    end

    always @(posedge clk) begin
        if (!core_en) begin
            model_done <= 1'b0;
            model_cnt  <= 0;
        end else if (core_start) begin
            model_done <= 1'b0;
            model_n    <= core_din;
            model_cnt  <= int'($urandom_range(1, 6));
        end else if (model_cnt > 0) begin
            model_cnt <= model_cnt - 1;
            if (model_cnt == 1) begin
                model_done <= 1'b1;
                model_dout <= fib(int'(model_n));
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offer a job and advance to the START cycle; checks the start pulse and driven index.
    task automatic issue(input logic [DW-1:0] n, input bit drop_valid);
        int k;
        req_n     = n;
        req_valid = 1'b1;
        k = 0;
        while (!req_ready && k < 50) begin
            step();
            k++;
        end
        if (k == 50) check("req_ready_bound", 32'(k), 32'd0);
        step();
        check("core_start_pulse", 32'(core_start), 32'd1);
        check("core_din", 32'(core_din), 32'(n));
        check("req_ready_busy", 32'(req_ready), 32'd0);
        if (drop_valid) req_valid = 1'b0;
    endtask

    // Step until rsp_valid; returns the number of steps taken from the START cycle.
    task automatic wait_rsp(output int cyc);
        logic extra_start;
        extra_start = 1'b0;
        cyc = 0;
        while (!rsp_valid && cyc < 40) begin
            step();
            cyc++;
            extra_start |= core_start;
        end
        if (cyc == 40) check("rsp_valid_bound", 32'(cyc), 32'd0);
        check("single_start", 32'(extra_start), 32'd0);
    endtask

    task automatic finish_rsp(input bit was_to);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        if (was_to) begin
            if (exp_to < 255) exp_to++;
        end else begin
            if (exp_jobs < 65535) exp_jobs++;
        end
        check("rsp_valid_drop", 32'(rsp_valid), 32'd0);
        check("jobs_done", 32'(jobs_done), 32'(exp_jobs));
        check("timeouts", 32'(timeouts), 32'(exp_to));
    endtask

    task automatic check_reset_outputs();
        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_core_start", 32'(core_start), 32'd0);
        check("rst_core_din", 32'(core_din), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_n", 32'(rsp_n), 32'd0);
        check("rst_rsp_value", 32'(rsp_value), 32'd0);
        check("rst_rsp_timeout", 32'(rsp_timeout), 32'd0);
        check("rst_jobs_done", 32'(jobs_done), 32'd0);
        check("rst_timeouts", 32'(timeouts), 32'd0);
    endtask

    initial begin
        int cyc;
        int bp;
        logic [DW-1:0] n;
        logic [DW-1:0] seq_n [5];
        logic [15:0]   seq_v [5];
        seq_n = '{16'd0, 16'd1, 16'd5, 16'd10, 16'd24};
        seq_v = '{16'd0, 16'd1, 16'd5, 16'd55, 16'd46368};

        reset      = 1'b0;
        req_valid  = 1'b0;
        req_n      = '0;
        rsp_ready  = 1'b0;
        core_en    = 1'b1;
        force_done = 1'b0;
        force_dout = '0;
        #3;
        check_reset_outputs();
        step();
        step();
        reset = 1'b1;

        // Sequential single jobs against known Fibonacci values
        for (int i = 0; i < 5; i++) begin
            issue(seq_n[i], 1'b1);
            wait_rsp(cyc);
            check("seq_rsp_value", 32'(rsp_value), 32'(seq_v[i]));
            check("seq_rsp_n", 32'(rsp_n), 32'(seq_n[i]));
            check("seq_rsp_timeout", 32'(rsp_timeout), 32'd0);
            finish_rsp(1'b0);
        end
        check("seq_jobs_total", 32'(jobs_done), 32'd5);

        // Back-to-back with a held request and downstream backpressure
        issue(16'd3, 1'b0);
        req_n = 16'd7;
        wait_rsp(cyc);
        for (int i = 0; i < 5; i++) begin
            check("bp_rsp_valid", 32'(rsp_valid), 32'd1);
            check("bp_rsp_n", 32'(rsp_n), 32'd3);
            check("bp_rsp_value", 32'(rsp_value), 32'd2);
            check("bp_req_ready", 32'(req_ready), 32'd0);
            check("bp_no_start", 32'(core_start), 32'd0);
            step();
        end
        finish_rsp(1'b0);
        check("b2b_req_ready", 32'(req_ready), 32'd1);
        step();
        check("b2b_start", 32'(core_start), 32'd1);
        check("b2b_din", 32'(core_din), 32'd7);
        req_valid = 1'b0;
        wait_rsp(cyc);
        check("b2b_rsp_value", 32'(rsp_value), 32'd13);
        check("b2b_rsp_n", 32'(rsp_n), 32'd7);
        finish_rsp(1'b0);

        // Randomized jobs with random backpressure
        for (int j = 0; j < 8; j++) begin
            n  = DW'($urandom_range(0, 24));
            bp = int'($urandom_range(0, 3));
            issue(n, 1'b1);
            wait_rsp(cyc);
            for (int i = 0; i < bp; i++) step();
            check("rnd_rsp_value", 32'(rsp_value), 32'(fib(int'(n))));
            check("rnd_rsp_n", 32'(rsp_n), 32'(n));
            check("rnd_rsp_timeout", 32'(rsp_timeout), 32'd0);
            finish_rsp(1'b0);
        end

        // Timeout with a silent core
        core_en = 1'b0;
        step();
        issue(16'd4, 1'b1);
        wait_rsp(cyc);
        check("to_latency", 32'(cyc), 32'(TIMEOUT + 1));
        check("to_flag", 32'(rsp_timeout), 32'd1);
        check("to_value", 32'(rsp_value), 32'd0);
        check("to_rsp_n", 32'(rsp_n), 32'd4);
        finish_rsp(1'b1);

        // Done arriving on the last WAIT cycle beats the timeout
        issue(16'd9, 1'b1);
        for (int i = 0; i < TIMEOUT; i++) step();
        check("race_pre_valid", 32'(rsp_valid), 32'd0);
        force_done = 1'b1;
        force_dout = 16'h1234;
        step();
        force_done = 1'b0;
        check("race_rsp_valid", 32'(rsp_valid), 32'd1);
        check("race_value", 32'(rsp_value), 32'h1234);
        check("race_flag", 32'(rsp_timeout), 32'd0);
        finish_rsp(1'b0);

        // Stale done in IDLE and START must not complete a job
        force_done = 1'b1;
        force_dout = 16'hBEEF;
        for (int i = 0; i < 3; i++) begin
            step();
            check("stale_idle_valid", 32'(rsp_valid), 32'd0);
            check("stale_idle_ready", 32'(req_ready), 32'd1);
        end
        issue(16'd2, 1'b1);
        step();
        force_done = 1'b0;
        check("stale_start_valid", 32'(rsp_valid), 32'd0);
        wait_rsp(cyc);
        check("stale_flag", 32'(rsp_timeout), 32'd1);
        check("stale_value", 32'(rsp_value), 32'd0);
        finish_rsp(1'b1);

        // Asynchronous reset in WAIT, then a late done
        issue(16'd6, 1'b1);
        for (int i = 0; i < 3; i++) step();
        reset = 1'b0;
        #1;
        check_reset_outputs();
        step();
        reset = 1'b1;
        exp_jobs = 0;
        exp_to   = 0;
        force_done = 1'b1;
        force_dout = 16'h5555;
        step();
        force_done = 1'b0;
        cyc = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (rsp_valid) cyc++;
        end
        check("late_done_no_rsp", 32'(cyc), 32'd0);
        check("post_rst_jobs", 32'(jobs_done), 32'd0);
        check("post_rst_timeouts", 32'(timeouts), 32'd0);
        check("post_rst_ready", 32'(req_ready), 32'd1);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
